tree_ensemble_walker: RTL
=========================

// Module: tree_ensemble_walker
// PURPOSE
//  Evaluates an ensemble of N_TREES binary decision trees for one feature vector; returns signed sum of the N_TREES leaf values.
//  Trees packed contiguously in one external node memory (tree t at base t*N_NODE); features read from external feature store.
//  Walk is sequential (tree 0..N_TREES-1), one node at a time.
//  Adds over single-tree walker: configurable memory latency, ensemble accumulation, depth/index error detection, result backpressure.
// PARAMETERS
//  N_TREES    4    trees per ensemble (>=1)
//  N_NODE     256  node slots per tree (<=256; tree-local indices are 8 bit)
//  N_FEATURE  32   features per vector (<=256)
//  MAX_DEPTH  16   max decision nodes visited per tree before error
//  MEM_LAT    1    node-memory read latency in cycles (>=1)
//  Derived: AW=$clog2(N_TREES*N_NODE), FW=$clog2(N_FEATURE), SW=32+$clog2(N_TREES)+1
// PORTS
//  clk           in   1    clock
//  rst_n         in   1    reset, asynchronous, active-low
//  start         in   1    begin evaluation; accepted only when start_ready=1
//  start_ready   out  1    1 in IDLE
//  node_rd       out  1    node read strobe, 1 cycle
//  node_addr     out  AW   global node address = tree*N_NODE + local index
//  node_rdata    in   64   node word, valid exactly MEM_LAT cycles after node_rd
//  feature_rd    out  1    feature read strobe, 1 cycle
//  feature_index out  FW   feature selector
//  feature       in   32   signed feature, valid exactly 1 cycle after feature_rd
//  res_valid     out  1    result available; held until res_ready
//  res_ready     in   1    consumer accepts result
//  res_sum       out  SW   signed sum of leaf values (sign-extended adds)
//  res_err       out  1    evaluation aborted on error; res_sum = partial sum
//  busy          out  1    not IDLE
// BEHAVIOUR
//  Node word (little-end bits): [0] is_node (1=decision, 0=leaf), [15:8] f_index, [23:16] right index (local), [63:32] signed value; other bits ignored.
//  Reset: FSM IDLE; start_ready=1; node_rd, feature_rd, res_valid, res_err, busy=0; res_sum, node_addr, feature_index=0.
//  FSM: IDLE -> FETCH -> WAIT_NODE -> (FEAT -> COMPARE -> FETCH | ACCUM) ... -> RESULT -> IDLE.
//   IDLE: start=1 -> clear sum/err, tree=0, local=0, depth=0 -> FETCH.
//   FETCH: node_rd=1 for this cycle, node_addr held until next FETCH. -> WAIT_NODE.
//   WAIT_NODE: count MEM_LAT cycles; capture node_rdata on last. Leaf -> ACCUM; decision -> FEAT.
//   FEAT: if f_index>=N_FEATURE -> error; else feature_rd=1, feature_index=f_index -> COMPARE.
//   COMPARE: signed feature<value -> local+1, else local=right; depth+1.
//     Error if depth reaches MAX_DEPTH, next local >= N_NODE, or right<=local (non-forward); else -> FETCH.
//   ACCUM: sum += sext(value). Last tree -> RESULT; else tree+1, local=0, depth=0 -> FETCH.
//   Error: res_err=1, remaining trees skipped -> RESULT.
//   RESULT: res_valid=1, res_sum/res_err stable; on res_ready -> IDLE next cycle. start ignored outside IDLE.
//  Cycle cost: decision node MEM_LAT+3 cycles; leaf MEM_LAT+2 (incl. ACCUM). start->res_valid (root leaves) = N_TREES*(MEM_LAT+2)+1.
//  Sum cannot overflow (SW has guard bits). Local index wraps are impossible: out-of-range flagged before use.
//  Async reset mid-walk: immediate return to reset values; no partial result emitted; in-flight node_rdata/feature ignored.
// STRUCTURE
//  Shared package tree_pkg: tree_node_t packed struct (64-bit layout above), walker_state_e enum, NODE_W=64, VALUE_W=32.
//  No sub-module; single FSM + datapath (MEM_LAT down-counter, depth counter, accumulator) in this file.
// TESTING
//  N_TREES=1, root leaf value=-5 -> res_sum=-5, res_err=0, res_valid at cycle MEM_LAT+3 after start.
//  N_TREES=2, tree0 root f0<10 (f0=3) -> local1 leaf 7; tree1 f1=20>=10 -> right=2 leaf 100 -> res_sum=107.
//  MEM_LAT=3: node_rdata driven only at exact latency, garbage otherwise -> correct sum; node_rd spacing 6 cycles per decision node.
//  Chain of 16 decision nodes (MAX_DEPTH=16), right=local -> res_err=1, res_sum = prior trees' partial sum.
//  res_ready low 10 cycles -> res_valid/res_sum stable; start pulses ignored; accepted next cycle after res_ready.
//  Assert rst_n mid-WAIT_NODE -> all outputs at reset values same cycle; new start after release evaluates correctly.

Source files
------------

// File: rtl/tree_pkg.sv
// tree_pkg: node word layout and walker state encoding shared by the ensemble walker.
package tree_pkg;
  localparam int NODE_W = 64;
  localparam int VALUE_W = 32;
  typedef struct packed {
    logic signed [VALUE_W-1:0] value;
    logic [7:0]                rsvd_hi;
    logic [7:0]                right;
    logic [7:0]                f_index;
    logic [6:0]                rsvd_lo;
    logic                      is_node;
  } tree_node_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_NODE,
    S_FEAT,
    S_COMPARE,
    S_ACCUM,
    S_RESULT
  } walker_state_e;
endpackage

// File: rtl/tree_ensemble_walker.sv
// tree_ensemble_walker: walks N_TREES packed decision trees in turn and returns the signed sum of their leaves.
module tree_ensemble_walker
  import tree_pkg::*;
#(
  parameter int N_TREES   = 4,
  parameter int N_NODE    = 256,
  parameter int N_FEATURE = 32,
  parameter int MAX_DEPTH = 16,
  parameter int MEM_LAT   = 1,
  localparam int AW = $clog2(N_TREES * N_NODE),
  localparam int FW = $clog2(N_FEATURE),
  localparam int SW = 32 + $clog2(N_TREES) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 start_ready,
  output logic                 node_rd,
  output logic [AW-1:0]        node_addr,
  input  logic [NODE_W-1:0]    node_rdata,
  output logic                 feature_rd,
  output logic [FW-1:0]        feature_index,
  input  logic signed [31:0]   feature,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [SW-1:0] res_sum,
  output logic                 res_err,
  output logic                 busy
);
  localparam int TW = (N_TREES > 1) ? $clog2(N_TREES) : 1;
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int LW = $clog2(MEM_LAT + 1);

  walker_state_e      state_q, state_d;
  logic [TW-1:0]      tree_q, tree_d;
  logic [7:0]         local_q, local_d;
  logic [DW-1:0]      depth_q, depth_d;
  logic [LW-1:0]      lat_q, lat_d;
  tree_node_t         node_q, node_d;
  logic signed [SW-1:0] sum_q, sum_d;
  logic               err_q, err_d;
  logic               node_rd_q, node_rd_d;
  logic [AW-1:0]      node_addr_q, node_addr_d;
  logic               feature_rd_q, feature_rd_d;
  logic [FW-1:0]      feature_index_q, feature_index_d;
  logic               res_valid_q, res_valid_d;
  logic               go_left, feat_bad, bad_step;
  logic [8:0]         nxt_local;
  logic [DW-1:0]      depth_inc;
  logic               unused_bits;

  assign unused_bits = ^{node_q.rsvd_hi, node_q.rsvd_lo};

  always_comb begin
    state_d         = state_q;
    tree_d          = tree_q;
    local_d         = local_q;
    depth_d         = depth_q;
    lat_d           = lat_q;
    node_d          = node_q;
    sum_d           = sum_q;
    err_d           = err_q;
    go_left         = $signed(feature) < $signed(node_q.value);
    nxt_local       = go_left ? 9'(local_q) + 9'd1 : 9'(node_q.right);
    depth_inc       = depth_q + DW'(1);
    feat_bad        = {1'b0, node_q.f_index} >= 9'(N_FEATURE);
    // right branch must strictly advance so the walk always terminates
    bad_step        = (depth_inc == DW'(MAX_DEPTH)) || (nxt_local >= 9'(N_NODE)) ||
                      (!go_left && (node_q.right <= local_q));
    case (state_q)
      S_IDLE: if (start) begin
        sum_d   = '0;
        err_d   = 1'b0;
        tree_d  = '0;
        local_d = '0;
        depth_d = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        lat_d   = LW'(MEM_LAT - 1);
        state_d = S_WAIT_NODE;
      end
      S_WAIT_NODE: if (lat_q == '0) begin
        node_d  = tree_node_t'(node_rdata);
        state_d = node_d.is_node ? S_FEAT : S_ACCUM;
      end else begin
        lat_d = lat_q - LW'(1);
      end
      S_FEAT: begin
        err_d   = feat_bad;
        state_d = feat_bad ? S_RESULT : S_COMPARE;
      end
      S_COMPARE: begin
        depth_d = depth_inc;
        err_d   = bad_step;
        local_d = bad_step ? local_q : nxt_local[7:0];
        state_d = bad_step ? S_RESULT : S_FETCH;
      end
      S_ACCUM: begin
        sum_d = sum_q + SW'($signed(node_q.value));
        if (tree_q == TW'(N_TREES - 1)) begin
          state_d = S_RESULT;
        end else begin
          tree_d  = tree_q + TW'(1);
          local_d = '0;
          depth_d = '0;
          state_d = S_FETCH;
        end
      end
      S_RESULT: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    node_rd_d       = state_d == S_FETCH;
    node_addr_d     = node_rd_d ? AW'(32'(tree_d) * N_NODE + 32'(local_d)) : node_addr_q;
    feature_rd_d    = (state_d == S_FEAT) && ({1'b0, node_d.f_index} < 9'(N_FEATURE));
    feature_index_d = feature_rd_d ? node_d.f_index[FW-1:0] : feature_index_q;
    res_valid_d     = state_d == S_RESULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      tree_q          <= '0;
      local_q         <= '0;
      depth_q         <= '0;
      lat_q           <= '0;
      node_q          <= '0;
      sum_q           <= '0;
      err_q           <= 1'b0;
      node_rd_q       <= 1'b0;
      node_addr_q     <= '0;
      feature_rd_q    <= 1'b0;
      feature_index_q <= '0;
      res_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      tree_q          <= tree_d;
      local_q         <= local_d;
      depth_q         <= depth_d;
      lat_q           <= lat_d;
      node_q          <= node_d;
      sum_q           <= sum_d;
      err_q           <= err_d;
      node_rd_q       <= node_rd_d;
      node_addr_q     <= node_addr_d;
      feature_rd_q    <= feature_rd_d;
      feature_index_q <= feature_index_d;
      res_valid_q     <= res_valid_d;
    end
  end

  assign start_ready   = state_q == S_IDLE;
  assign busy          = state_q != S_IDLE;
  assign node_rd       = node_rd_q;
  assign node_addr     = node_addr_q;
  assign feature_rd    = feature_rd_q;
  assign feature_index = feature_index_q;
  assign res_valid     = res_valid_q;
  assign res_sum       = sum_q;
  assign res_err       = err_q;
endmodule
